// File: rtl/sd_sector_cache_pkg.sv
// Shared definitions for the SD single-sector read cache.
// Provides the cache FSM state type and the sector geometry constants used by
// sd_sector_cache and sd_sector_ram.
package sd_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_WORDS = 128;
  localparam int unsigned SECTOR_SHIFT = 9;

  // StLookup is reserved; the tag compare is resolved directly in StIdle.
  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StReq,
    StFill,
    StRead,
    StResp,
    StErr
  } cache_state_e;

endpackage

// File: rtl/sd_sector_ram.sv
// 128x32 sector buffer: one write port with per-byte-lane enables and one
// read port with a registered output (data appears the cycle after re_i).
// Ports:
//   clk_i    clock
//   we_i     byte-lane write enables, lane i = wdata_i[8i+7:8i]
//   waddr_i  write word address
//   wdata_i  write data
//   re_i     read enable; rdata_o holds its value while re_i is low
//   raddr_i  read word address
//   rdata_o  registered read data
module sd_sector_ram
  import sd_pkg::*;
(
  input  logic        clk_i,
  input  logic [3:0]  we_i,
  input  logic [6:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        re_i,
  input  logic [6:0]  raddr_i,
  output logic [31:0] rdata_o
);

  logic [31:0] mem_q [SECTOR_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_sector_cache.sv
// Single-sector read cache between the SD block-read controller and the CPU
// data bus. Word reads on a byte address hit in the buffered sector or
// trigger a whole-sector fetch, packing the byte stream little-endian.
// Ports:
//   clk_25mhz, rst_n           clock, synchronous active-low reset
//   mem_req/mem_addr           CPU read request (level) and byte address
//   mem_rdata/mem_ready/mem_err  one-cycle completion, err => rdata = 0
//   invalidate                 drop the cached sector
//   sd_rd_req/sd_rd_sector/sd_rd_ack  sector request handshake
//   sd_byte_valid/sd_byte      incoming sector bytes, order 0..511
//   sd_rd_done/sd_rd_err       end-of-sector / failure pulses
module sd_sector_cache
  import sd_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  input  logic              invalidate,
  output logic              sd_rd_req,
  output logic [31:0]       sd_rd_sector,
  input  logic              sd_rd_ack,
  input  logic              sd_byte_valid,
  input  logic [7:0]        sd_byte,
  input  logic              sd_rd_done,
  input  logic              sd_rd_err
);

  localparam int unsigned TAG_W = ADDR_W - SECTOR_SHIFT;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0] FullCnt = 10'(SECTOR_BYTES);
  localparam logic [TMR_W-1:0] TmrMax = TMR_W'(TIMEOUT_CYCLES);

  cache_state_e     state_q, state_d;
  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] sector_q, sector_d;
  logic [6:0]       word_q, word_d;
  logic [9:0]       cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic [TAG_W-1:0] req_sector;
  logic             hit;
  logic             timed_out;
  logic             byte_wr;
  logic [9:0]       cnt_after;
  logic [3:0]       ram_we;
  logic [31:0]      ram_rdata;
  logic             unused_addr;

  assign req_sector  = mem_addr[ADDR_W-1:SECTOR_SHIFT];
  assign hit         = valid_q && (tag_q == req_sector);
  assign timed_out   = (tmr_q == TmrMax);
  assign unused_addr = ^mem_addr[1:0];

  // A byte arriving with the counter already at 512 is an overrun: never written.
  assign byte_wr   = (state_q == StFill) && sd_byte_valid && (cnt_q != FullCnt);
  assign cnt_after = cnt_q + 10'(byte_wr);
  assign ram_we    = byte_wr ? (4'b0001 << cnt_q[1:0]) : 4'b0000;

  sd_sector_ram u_ram (
    .clk_i   (clk_25mhz),
    .we_i    (ram_we),
    .waddr_i (cnt_q[8:2]),
    .wdata_i ({4{sd_byte}}),
    .re_i    (state_q == StRead),
    .raddr_i (word_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    sector_d = sector_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    tmr_d    = tmr_q;

    // Saturating fetch timer, covering REQ and FILL together.
    if ((state_q == StReq || state_q == StFill) && !timed_out) begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (invalidate) valid_d = 1'b0;
        if (mem_req) begin
          word_d = mem_addr[8:2];
          if (hit) begin
            state_d = StRead;
          end else begin
            state_d  = StReq;
            sector_d = req_sector;
            tmr_d    = '0;
            kill_d   = 1'b0;
          end
        end
      end
      StReq: begin
        if (invalidate) kill_d = 1'b1;
        if (timed_out) begin
          state_d = StErr;
        end else if (sd_rd_ack) begin
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (invalidate) kill_d = 1'b1;
        cnt_d = cnt_after;
        if (timed_out || sd_rd_err || (sd_byte_valid && cnt_q == FullCnt)) begin
          state_d = StErr;
        end else if (sd_rd_done) begin
          // Count includes a byte landing in the same cycle as done.
          if (cnt_after == FullCnt) begin
            valid_d = !(kill_q || invalidate);
            tag_d   = sector_q;
            state_d = StRead;
          end else begin
            state_d = StErr;
          end
        end
      end
      StRead: begin
        if (invalidate) valid_d = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        if (invalidate) valid_d = 1'b0;
        state_d = StIdle;
      end
      StErr: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      sector_q <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      sector_q <= sector_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      kill_q   <= kill_d;
      tmr_q    <= tmr_d;
    end
  end

  assign mem_ready    = (state_q == StResp) || (state_q == StErr);
  assign mem_err      = (state_q == StErr);
  assign mem_rdata    = (state_q == StResp) ? ram_rdata : 32'h0;
  assign sd_rd_req    = (state_q == StReq);
  assign sd_rd_sector = 32'(sector_q);

endmodule
